param_mini_cpu: RTL

PARAM_MINI_CPU -- requirements
Module: param_mini_cpu

---
 rtl/param_mini_cpu_if.sv | 12 +
 rtl/param_mini_cpu.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/param_mini_cpu_if.sv
// Output-port handshake between the mini CPU and its consumer.
// The CPU drives data and valid; the consumer drives ready.
interface param_mini_cpu_if #(
    parameter int DATA_W = 8
);
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/param_mini_cpu.sv
// Parameterized 3-cycle multicycle CPU with a loadable instruction memory,
// an ALU with Z/C flags, a conditional jump and a stalling output port.
module param_mini_cpu #(
    parameter  int DATA_W     = 8,
    parameter  int NREGS      = 8,
    parameter  int IMEM_DEPTH = 16,
    localparam int RA         = $clog2(NREGS),
    localparam int PA         = $clog2(IMEM_DEPTH),
    localparam int IW         = 4 + 3 * RA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we_i,
    input  logic [PA-1:0]     prog_addr_i,
    input  logic [IW-1:0]     prog_data_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              halted_o,
    output logic              flag_z_o,
    output logic              flag_c_o,
    input  logic [RA-1:0]     dbg_sel_i,
    output logic [DATA_W-1:0] dbg_data_o,
    param_mini_cpu_if.master  out_if
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT_OUT, S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
                           OP_OR  = 4'd3, OP_XOR = 4'd4, OP_LDI = 4'd5,
                           OP_MOV = 4'd6, OP_OUT = 4'd7, OP_JZ  = 4'd8,
                           OP_HLT = 4'd9;

    state_t            state_q;
    logic [IW-1:0]     imem [IMEM_DEPTH];
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [IW-1:0]     ir_q;
    logic [PA-1:0]     pc_q;
    logic [DATA_W-1:0] opa_q, opb_q, out_data_q;
    logic              flag_z_q, flag_c_q, out_valid_q, busy_q, halted_q;

    logic [3:0]        opc;
    logic [RA-1:0]     rd, rs1, rs2;
    logic [2*RA-1:0]   imm;
    logic [PA-1:0]     pc_inc;
    logic [DATA_W:0]   alu_d;

    assign opc    = ir_q[IW-1 -: 4];
    assign rd     = ir_q[3*RA-1 -: RA];
    assign rs1    = ir_q[2*RA-1 -: RA];
    assign rs2    = ir_q[RA-1:0];
    assign imm    = ir_q[2*RA-1:0];
    assign pc_inc = pc_q + PA'(1);

    // Extra MSB carries the carry out on ADD and the borrow on SUB.
    always_comb begin
        alu_d = '0;
        case (opc)
            OP_ADD:  alu_d = {1'b0, opa_q} + {1'b0, opb_q};
            OP_SUB:  alu_d = {1'b0, opa_q} - {1'b0, opb_q};
            OP_AND:  alu_d = {1'b0, opa_q & opb_q};
            OP_OR:   alu_d = {1'b0, opa_q | opb_q};
            OP_XOR:  alu_d = {1'b0, opa_q ^ opb_q};
            default: alu_d = '0;
        endcase
    end

    // Program memory is not reset so a program survives a CPU reset.
    always_ff @(posedge clk) begin
        if (prog_we_i && (state_q == S_IDLE || state_q == S_HALT))
            imem[prog_addr_i] <= prog_data_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start_i) begin
                        pc_q     <= '0;
                        state_q  <= S_FETCH;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir_q    <= imem[pc_q];
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    opa_q   <= regs_q[rs1];
                    opb_q   <= regs_q[rs2];
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    pc_q    <= pc_inc;
                    state_q <= S_FETCH;
                    case (opc)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            regs_q[rd] <= alu_d[DATA_W-1:0];
                            flag_z_q   <= (alu_d[DATA_W-1:0] == '0);
                            flag_c_q   <= alu_d[DATA_W];
                        end
                        OP_LDI: regs_q[rd] <= DATA_W'(imm);
                        OP_MOV: regs_q[rd] <= opa_q;
                        OP_OUT: begin
                            pc_q        <= pc_q;
                            out_data_q  <= opa_q;
                            out_valid_q <= 1'b1;
                            state_q     <= S_WAIT_OUT;
                        end
                        OP_JZ:  if (flag_z_q) pc_q <= PA'(imm);
                        OP_HLT: begin
                            pc_q     <= pc_q;
                            state_q  <= S_HALT;
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_WAIT_OUT: begin
                    if (out_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        pc_q        <= pc_inc;
                        state_q     <= S_FETCH;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign halted_o         = halted_q;
    assign flag_z_o         = flag_z_q;
    assign flag_c_o         = flag_c_q;
    assign dbg_data_o       = regs_q[dbg_sel_i];
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
endmodule
